decode_sequencer: RTL
=====================

Name: decode_sequencer

Overview:
- Top-level controller that sequences the image decoder flow: UART image load, then Milestone 2 (IDCT), then Milestone 1 (upsample/CSC), then VGA display.
- Owns the single external SRAM port and multiplexes address, write data and we_n among UART, M2, M1 and VGA according to its state.
- Generates the UART initialize/enable handshake, the M1/M2 start levels and VGA_enable.
- Sits between the SRAM_controller and the UART_SRAM_interface, M1, M2 and VGA_SRAM_interface units.

Parameters:
- TIMEOUT_CYCLES, 50000000, idle-line cycles after the last UART write before the load is declared complete (1 s at 50 MHz).
- TIMER_W, 26, timer width; must satisfy 2^TIMER_W > TIMEOUT_CYCLES.
- WDOG_CYCLES, 33554431, per-milestone cycle limit (used only with the optional feature).

Ports:
- Clock  in  1  system clock, 50 MHz.
- resetn  in  1  synchronous active-low reset.
- UART_RX_I  in  1  raw UART line; 0 = start bit.
- UART_SRAM_address  in  18  UART write address.
- UART_SRAM_write_data  in  16  UART write data.
- UART_SRAM_we_n  in  1  UART write strobe, active low.
- UART_rx_initialize  out  1  UART interface initialize pulse.
- UART_rx_enable  out  1  UART interface enable.
- M2_address / M2_write_data / M2_we_n  in  18/16/1  M2 SRAM request.
- M2_done  in  1  M2 completion pulse or level.
- M2_start  out  1  M2 run level.
- M1_address / M1_write_data / M1_we_n  in  18/16/1  M1 SRAM request.
- M1_done  in  1  M1 completion.
- M1_start  out  1  M1 run level.
- VGA_SRAM_address  in  18  VGA read address.
- VGA_enable  out  1  VGA fetch enable.
- SRAM_address  out  18  to SRAM_controller.
- SRAM_write_data  out  16  to SRAM_controller.
- SRAM_we_n  out  1  to SRAM_controller.
- seq_state  out  2  current state: 0 = IDLE, 1 = UART_RX, 2 = M2, 3 = M1.
- seq_error  out  1  watchdog abort flag (0 when the optional feature is compiled out).

Behaviour:
- All sequential logic updates on posedge Clock; reset is synchronous.
- Reset values: state IDLE, timer 0, UART_rx_initialize 0, UART_rx_enable 0, M1_start 0, M2_start 0, VGA_enable 1, seq_error 0.
- Reset asserted mid-operation aborts any state within one clock. Starts drop, so M1/M2 see start=0 on the next edge.
- SRAM mux is combinational from the registered state:
  - UART_RX selects UART inputs; M2 selects M2 inputs; M1 selects M1 inputs.
  - IDLE selects VGA_SRAM_address, write data 16'd0, we_n 1.
  - Write strobe in IDLE is therefore never asserted.
- IDLE:
  - VGA_enable = 1.
  - If UART_RX_I == 0: UART_rx_initialize <= 1, timer <= 0, VGA_enable <= 0, go to UART_RX.
- UART_RX:
  - UART_rx_initialize <= 0 every cycle.
  - UART_rx_enable <= 1 exactly when UART_rx_initialize was 1, else 0. The result is a 1-cycle enable pulse, one cycle after initialize.
  - Timer increments every cycle.
  - UART_SRAM_we_n == 0 clears the timer; a clear takes priority over the timeout compare in the same cycle.
  - When timer == TIMEOUT_CYCLES-1 and no write that cycle: timer <= 0, M2_start <= 1, go to M2.
- M2:
  - M2_start is held at 1.
  - M2_done is ignored in the first cycle in the state, because the slave has not yet seen start.
  - On a qualified M2_done: M2_start <= 0, M1_start <= 1, go to M1. The handoff has no idle cycle.
- M1:
  - Same done-qualification rule.
  - On a qualified M1_done: M1_start <= 0, VGA_enable <= 1, go to IDLE.
- UART_RX_I activity while in M2 or M1 is ignored. No reload starts until IDLE.
- Illegal or unknown state goes to IDLE with all starts 0.
- Timer arithmetic is TIMER_W-bit unsigned. The timer never wraps inside UART_RX because the compare fires first.

Optional Feature:
- Macro: SEQ_WATCHDOG_EN.
- When defined:
  - A TIMER_W-bit watchdog clears on entry to M2 and on entry to M1, and increments in those states.
  - On reaching WDOG_CYCLES without a qualified done: both starts <= 0, seq_error <= 1, go to IDLE.
  - seq_error stays 1 until reset or the next IDLE-to-UART_RX transition.
- When undefined: no watchdog logic; seq_error is tied to 0.

Test Plan:
- Reset: hold resetn=0 for 3 cycles, then release -> seq_state=0, VGA_enable=1, starts 0, SRAM_we_n=1, SRAM_address=VGA_SRAM_address.
- Load entry and timeout (TIMEOUT_CYCLES=100): UART_RX_I=0 in IDLE -> next cycle seq_state=1, UART_rx_initialize=1; the cycle after, initialize=0 and enable=1. No writes -> M2_start=1 exactly 100 cycles after the timer clear.
- Timeout/write collision: UART_SRAM_we_n=0 on the cycle timer==99 -> state stays UART_RX, timer=0. The mux passes UART_SRAM_address 0x00ABC and data 0x1234 to the SRAM outputs.
- Chain: M2_done pulsed 50 cycles into M2 -> next cycle M2_start=0, M1_start=1, seq_state=3. M1_done -> seq_state=0, VGA_enable=1. M1_we_n=0 during M1 propagates to SRAM_we_n.
- Early done and mid-run reset: M2_done=1 on the first cycle of M2 -> ignored. resetn=0 during M1 -> next cycle M1_start=0, seq_state=0.
- Watchdog (SEQ_WATCHDOG_EN, WDOG_CYCLES=20): M1_done never asserted -> after 20 cycles in M1, M1_start=0, seq_error=1, seq_state=0.

Source files
------------

// File: rtl/decode_sequencer_if.sv
// SRAM request bus driven by the decode sequencer towards the SRAM controller.
interface decode_sequencer_if;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    modport master (
        output SRAM_address,
        output SRAM_write_data,
        output SRAM_we_n
    );

    modport slave (
        input SRAM_address,
        input SRAM_write_data,
        input SRAM_we_n
    );
endinterface

// File: rtl/decode_sequencer.sv
// Image decoder flow controller: UART load -> M2 -> M1 -> VGA, owns the SRAM port.
// Optional per-milestone watchdog: define SEQ_WATCHDOG_EN.
module decode_sequencer #(
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int TIMER_W        = 26,
    parameter int WDOG_CYCLES    = 33554431
) (
    input  logic        Clock,
    input  logic        resetn,
    input  logic        UART_RX_I,
    input  logic [17:0] UART_SRAM_address,
    input  logic [15:0] UART_SRAM_write_data,
    input  logic        UART_SRAM_we_n,
    output logic        UART_rx_initialize,
    output logic        UART_rx_enable,
    input  logic [17:0] M2_address,
    input  logic [15:0] M2_write_data,
    input  logic        M2_we_n,
    input  logic        M2_done,
    output logic        M2_start,
    input  logic [17:0] M1_address,
    input  logic [15:0] M1_write_data,
    input  logic        M1_we_n,
    input  logic        M1_done,
    output logic        M1_start,
    input  logic [17:0] VGA_SRAM_address,
    output logic        VGA_enable,
    decode_sequencer_if.master sram,
    output logic [1:0]  seq_state,
    output logic        seq_error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UART = 2'd1,
        S_M2   = 2'd2,
        S_M1   = 2'd3
    } state_t;

    localparam logic [TIMER_W-1:0] TO_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t             r_state, w_state_nx;
    logic [TIMER_W-1:0] r_timer, w_timer_nx;
    logic r_init, w_init_nx;
    logic r_en, w_en_nx;
    logic r_m2s, w_m2s_nx;
    logic r_m1s, w_m1s_nx;
    logic r_vga, w_vga_nx;
    logic r_first, w_first_nx;
    logic w_done_q;

`ifdef SEQ_WATCHDOG_EN
    localparam logic [TIMER_W-1:0] WD_LAST = TIMER_W'(WDOG_CYCLES - 1);
    logic [TIMER_W-1:0] r_wdog, w_wdog_nx;
    logic r_err, w_err_nx;
`endif

    always_ff @(posedge Clock) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_init  <= 1'b0;
            r_en    <= 1'b0;
            r_m2s   <= 1'b0;
            r_m1s   <= 1'b0;
            r_vga   <= 1'b1;
            r_first <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            r_wdog  <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_timer <= w_timer_nx;
            r_init  <= w_init_nx;
            r_en    <= w_en_nx;
            r_m2s   <= w_m2s_nx;
            r_m1s   <= w_m1s_nx;
            r_vga   <= w_vga_nx;
            r_first <= w_first_nx;
`ifdef SEQ_WATCHDOG_EN
            r_wdog  <= w_wdog_nx;
            r_err   <= w_err_nx;
`endif
        end
    end

    // Done is ignored on the first cycle in a state: the slave has not seen start yet.
    always_comb begin
        w_state_nx = r_state;
        w_timer_nx = r_timer;
        w_init_nx  = r_init;
        w_en_nx    = r_en;
        w_m2s_nx   = r_m2s;
        w_m1s_nx   = r_m1s;
        w_vga_nx   = r_vga;
        w_first_nx = 1'b0;
        w_done_q   = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        w_wdog_nx  = r_wdog + 1'b1;
        w_err_nx   = r_err;
`endif
        case (r_state)
            S_IDLE: begin
                w_init_nx = 1'b0;
                w_en_nx   = 1'b0;
                w_m2s_nx  = 1'b0;
                w_m1s_nx  = 1'b0;
                w_vga_nx  = 1'b1;
                if (!UART_RX_I) begin
                    w_init_nx  = 1'b1;
                    w_timer_nx = '0;
                    w_vga_nx   = 1'b0;
                    w_state_nx = S_UART;
`ifdef SEQ_WATCHDOG_EN
                    w_err_nx   = 1'b0;
`endif
                end
            end
            S_UART: begin
                w_init_nx = 1'b0;
                w_en_nx   = r_init;
                if (!UART_SRAM_we_n) begin
                    w_timer_nx = '0;
                end else if (r_timer == TO_LAST) begin
                    w_timer_nx = '0;
                    w_m2s_nx   = 1'b1;
                    w_first_nx = 1'b1;
                    w_state_nx = S_M2;
`ifdef SEQ_WATCHDOG_EN
                    w_wdog_nx  = '0;
`endif
                end else begin
                    w_timer_nx = r_timer + 1'b1;
                end
            end
            S_M2: begin
                w_m2s_nx = 1'b1;
                w_done_q = !r_first && M2_done;
                if (w_done_q) begin
                    w_m2s_nx   = 1'b0;
                    w_m1s_nx   = 1'b1;
                    w_first_nx = 1'b1;
                    w_state_nx = S_M1;
`ifdef SEQ_WATCHDOG_EN
                    w_wdog_nx  = '0;
`endif
                end
            end
            S_M1: begin
                w_done_q = !r_first && M1_done;
                if (w_done_q) begin
                    w_m1s_nx   = 1'b0;
                    w_vga_nx   = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_m2s_nx   = 1'b0;
                w_m1s_nx   = 1'b0;
                w_state_nx = S_IDLE;
            end
        endcase
`ifdef SEQ_WATCHDOG_EN
        if ((r_state == S_M2 || r_state == S_M1) &&
            !w_done_q && r_wdog == WD_LAST) begin
            w_m2s_nx   = 1'b0;
            w_m1s_nx   = 1'b0;
            w_vga_nx   = 1'b1;
            w_err_nx   = 1'b1;
            w_first_nx = 1'b0;
            w_state_nx = S_IDLE;
        end
`endif
    end

    always_comb begin
        sram.SRAM_address    = VGA_SRAM_address;
        sram.SRAM_write_data = 16'd0;
        sram.SRAM_we_n       = 1'b1;
        case (r_state)
            S_UART: begin
                sram.SRAM_address    = UART_SRAM_address;
                sram.SRAM_write_data = UART_SRAM_write_data;
                sram.SRAM_we_n       = UART_SRAM_we_n;
            end
            S_M2: begin
                sram.SRAM_address    = M2_address;
                sram.SRAM_write_data = M2_write_data;
                sram.SRAM_we_n       = M2_we_n;
            end
            S_M1: begin
                sram.SRAM_address    = M1_address;
                sram.SRAM_write_data = M1_write_data;
                sram.SRAM_we_n       = M1_we_n;
            end
            default: ;
        endcase
    end

    assign UART_rx_initialize = r_init;
    assign UART_rx_enable     = r_en;
    assign M2_start           = r_m2s;
    assign M1_start           = r_m1s;
    assign VGA_enable         = r_vga;
    assign seq_state          = r_state;
`ifdef SEQ_WATCHDOG_EN
    assign seq_error          = r_err;
`else
    assign seq_error          = 1'b0;
`endif

endmodule
